// File: rtl/layer_output_collector_pkg.sv
// Shared definitions for the layer output collector.
//   state_t   : collector FSM states (2-bit encoding)
//   idx_width : width of the beat index for a given neuron count.
//               The result is never less than 1, so that NUM_NEURONS=1
//               still gets a real register.
package layer_output_collector_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_STREAM  = 2'd2
  } state_t;

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/layer_output_slot.sv
// One capture slot: a WIDTH-bit value register plus its "captured" mask bit.
// The first valid after a clear wins. Later valids are ignored until the
// next clear.
// Ports:
//   CLK, RSTN  : clock, synchronous active-low reset
//   clear      : drop the captured flag (the value is left as is)
//   valid      : capture request
//   value      : value to capture
//   held_value : captured value
//   captured   : slot holds a value for the current pass
module layer_output_slot #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             clear,
  input  logic             valid,
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] held_value,
  output logic             captured
);

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      held_value <= '0;
      captured   <= 1'b0;
    end else if (clear) begin
      captured <= 1'b0;
    end else if (valid && !captured) begin
      held_value <= value;
      captured   <= 1'b1;
    end
  end

endmodule

// File: rtl/layer_output_collector.sv
// Collects one result per neuron of a layer, in any order, then streams the
// results in neuron-index order to the next layer. It also keeps a sticky
// layer-wide overflow flag.
// Ports:
//   CLK, RSTN          : clock, synchronous active-low reset
//   START              : arm a new collection (honoured in IDLE only)
//   NEURON_VALUE_IN    : packed neuron values, neuron i at [i*WIDTH +: WIDTH]
//   NEURON_VALID_IN    : per-neuron result-valid pulses
//   NEURON_OVERFLOW_IN : per-neuron overflow flags
//   DOWN_READY         : downstream accepts the current beat
//   VALUE_OUT          : streamed value
//   VALID_OUT          : VALUE_OUT is valid
//   LAST_OUT           : current beat belongs to neuron NUM_NEURONS-1
//   LAYER_OVERFLOW     : sticky OR of the neuron overflows for this pass
//   BUSY               : collecting or streaming
//   DONE               : one-cycle pulse after the last beat is accepted
//
// Handshake: a beat transfers on any rising CLK edge where VALID_OUT and
// DOWN_READY are both 1. VALID_OUT never depends combinationally on
// DOWN_READY. Once VALID_OUT is raised, VALUE_OUT, VALID_OUT and LAST_OUT
// stay stable until the beat transfers.
module layer_output_collector
  import layer_output_collector_pkg::*;
#(
  parameter int NUM_NEURONS = 4,
  parameter int WIDTH       = 8
) (
  input  logic                         CLK,
  input  logic                         RSTN,
  input  logic                         START,
  input  logic [NUM_NEURONS*WIDTH-1:0] NEURON_VALUE_IN,
  input  logic [NUM_NEURONS-1:0]       NEURON_VALID_IN,
  input  logic [NUM_NEURONS-1:0]       NEURON_OVERFLOW_IN,
  input  logic                         DOWN_READY,
  output logic signed [WIDTH-1:0]      VALUE_OUT,
  output logic                         VALID_OUT,
  output logic                         LAST_OUT,
  output logic                         LAYER_OVERFLOW,
  output logic                         BUSY,
  output logic                         DONE
);

  localparam int IDX_W = idx_width(NUM_NEURONS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  state_t state_q, state_d;

  logic [IDX_W-1:0]       idx_q;
  logic [IDX_W-1:0]       idx_nx;
  logic                   first_stream_q;
  logic [NUM_NEURONS-1:0] captured;
  logic [NUM_NEURONS-1:0] cap_req;
  logic [WIDTH-1:0]       held [NUM_NEURONS];
  logic                   clear_slots;
  logic                   all_captured;
  logic                   xfer;
  logic                   is_last;
  logic [WIDTH-1:0]       slot0_eff;

  // Neuron valids only count while collecting.
  assign cap_req = NEURON_VALID_IN & {NUM_NEURONS{state_q == ST_COLLECT}};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_NEURONS; gi++) begin : g_slot
      layer_output_slot #(.WIDTH(WIDTH)) u_slot (
        .CLK        (CLK),
        .RSTN       (RSTN),
        .clear      (clear_slots),
        .valid      (cap_req[gi]),
        .value      (NEURON_VALUE_IN[gi*WIDTH +: WIDTH]),
        .held_value (held[gi]),
        .captured   (captured[gi])
      );
    end
  endgenerate

  // Completion includes this cycle's captures, so streaming starts on the
  // edge that writes the final slot.
  assign all_captured = &(captured | cap_req);
  assign xfer         = VALID_OUT & DOWN_READY;
  assign is_last      = (idx_q == LAST_IDX);
  assign idx_nx       = idx_q + IDX_W'(1);
  // Slot 0 may be written on the same edge that launches the stream.
  // In that case, forward the incoming value.
  assign slot0_eff    = captured[0] ? held[0] : NEURON_VALUE_IN[WIDTH-1:0];

  always_ff @(posedge CLK) begin
    if (!RSTN) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    clear_slots = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d     = ST_COLLECT;
          clear_slots = 1'b1;
        end
      end
      ST_COLLECT: begin
        if (all_captured) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (xfer && is_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      VALUE_OUT      <= '0;
      VALID_OUT      <= 1'b0;
      LAST_OUT       <= 1'b0;
      LAYER_OVERFLOW <= 1'b0;
      BUSY           <= 1'b0;
      DONE           <= 1'b0;
      idx_q          <= '0;
      first_stream_q <= 1'b0;
    end else begin
      DONE           <= 1'b0;
      first_stream_q <= 1'b0;
      BUSY           <= (state_d != ST_IDLE);
      case (state_q)
        ST_IDLE: begin
          if (START) LAYER_OVERFLOW <= 1'b0;
        end
        ST_COLLECT: begin
          LAYER_OVERFLOW <= LAYER_OVERFLOW | (|NEURON_OVERFLOW_IN);
          if (all_captured) begin
            VALID_OUT      <= 1'b1;
            VALUE_OUT      <= slot0_eff;
            LAST_OUT       <= (NUM_NEURONS == 1);
            idx_q          <= '0;
            first_stream_q <= 1'b1;
          end
        end
        ST_STREAM: begin
          // A neuron's registered overflow lags its valid pulse by one
          // cycle. Sampling once more here catches the final neuron's flag.
          if (first_stream_q)
            LAYER_OVERFLOW <= LAYER_OVERFLOW | (|NEURON_OVERFLOW_IN);
          if (xfer) begin
            if (is_last) begin
              VALID_OUT <= 1'b0;
              LAST_OUT  <= 1'b0;
              DONE      <= 1'b1;
              idx_q     <= '0;
            end else begin
              idx_q     <= idx_nx;
              VALUE_OUT <= held[idx_nx];
              LAST_OUT  <= (idx_nx == LAST_IDX);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
